fetch_if_stage: RTL
===================

Name: fetch_if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It is the upstream end of the decode interface: it supplies instruction and PC to decode, and it consumes decode's hold, branch and exception outputs. It owns the PC, runs a request/ready handshake to instruction memory, buffers responses that arrive during stalls, and squashes wrong-path fetches on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
EXC_VECTOR, 32'h0000_0080, redirect target on exception
NOP, 32'h0000_0000, instruction word inserted for bubbles/squashes

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
hold_pc  input  1  from hazard unit: do not issue a new fetch
hold_if  input  1  from hazard unit: freeze IF/ID register
br  input  1  decode branch taken
pc_branch  input  32  branch target; bits [1:0] ignored, treated as 00
exception  input  1  decode exception; redirect to EXC_VECTOR
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (word aligned)
imem_ready  input  1  response valid this cycle (same-cycle allowed)
imem_rdata  input  32  instruction word, valid when imem_ready
inst_out  output  32  IF/ID instruction to decode
pc_out  output  32  IF/ID PC+4 of inst_out
valid_id  output  1  IF/ID holds a real instruction
flush_id  output  1  one-cycle pulse: IF/ID slot was squashed

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (clk, rst).
- On rst: pc_reg=RESET_PC, inst_out=NOP, pc_out=0, valid_id=0, flush_id=0, imem_req=0, buffer empty, state IDLE. Reset mid-request abandons the request; a late imem_ready is ignored.
- States: IDLE, FETCH, BUFFERED, DRAIN.
- IDLE: the first edge after rst deasserts moves to FETCH.
- FETCH: imem_req=1 unless hold_pc; imem_addr=pc_reg, stable until imem_ready.
  - imem_ready with no hold: IF/ID<={pc_reg+4, imem_rdata}, valid_id=1, pc_reg<=pc_reg+4. With a same-cycle-ready memory this sustains 1 instr/cycle.
  - No imem_ready and no hold: IF/ID<=NOP, valid_id=0 (bubble).
  - imem_ready while hold_if: IF/ID unchanged; rdata and pc_reg+4 go to the buffer; pc_reg<=pc_reg+4; go to BUFFERED.
- BUFFERED: imem_req=0, IF/ID frozen while hold_if. The first cycle with hold_if=0 loads the buffer into IF/ID, valid_id=1, then FETCH.
- hold_pc and hold_if are asserted together by the hazard unit. hold_if=1 always freezes inst_out/pc_out/valid_id.
- Redirect: exception has priority over br. br is ignored while hold_if=1. Target = EXC_VECTOR or {pc_branch[31:2],2'b00}.
  - Next edge: pc_reg<=target, IF/ID<=NOP, valid_id=0, flush_id=1 for exactly that cycle, buffer discarded.
  - If a request is outstanding without ready: go to DRAIN, imem_req stays high at the old address until imem_ready, and that response is dropped. Then FETCH at target.
  - If imem_ready arrives in the redirect cycle: the response is dropped and FETCH at target starts next cycle.
  - A redirect while in DRAIN updates the target only.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4=32'h0000_0000.
- flush_id is registered and is otherwise 0.

Test Plan:
- Reset, then imem_ready tied 1, rdata=addr: cycles 1..4 give inst_out 0,4,8,C and pc_out 4,8,C,10, valid_id=1.
- imem_ready every 3rd cycle: two NOP bubbles (valid_id=0) between instructions; imem_addr held stable while waiting.
- hold_pc=hold_if=1 for 3 cycles with ready during hold: IF/ID frozen, imem_req=0 after capture; on release the buffered word appears the next cycle with no instruction lost or duplicated.
- br=1, pc_branch=32'h0000_0043 with request pending: flush_id pulses one cycle, inst_out=NOP, old response dropped, next imem_addr=32'h0000_0040.
- exception and br in the same cycle: next fetch from 32'h0000_0080. br with hold_if=1: ignored, sequential PC continues.
- pc_reg=32'hFFFF_FFFC: pc_out=0 and next fetch at 0. Assert rst mid-DRAIN: outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_if_stage_if.sv
// fetch_if_stage_if: instruction-memory request/ready bus between the fetch stage and instruction memory
//   req   : fetch request (master -> slave)
//   addr  : word-aligned fetch address (master -> slave)
//   ready : response valid this cycle, may coincide with req (slave -> master)
//   rdata : instruction word, valid with ready (slave -> master)
interface fetch_if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master(output req, addr, input ready, rdata);
    modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_if_stage.sv
// fetch_if_stage: instruction fetch with PC, imem handshake, stall buffer, redirect squash and IF/ID register
//   clk, rst       : clock and asynchronous active-high reset
//   i_hold_pc      : do not issue a new fetch
//   i_hold_if      : freeze the IF/ID register
//   i_br           : branch taken (ignored while i_hold_if)
//   i_pc_branch    : branch target, low two bits forced to zero
//   i_exception    : redirect to EXC_VECTOR, wins over i_br
//   imem           : instruction-memory request/ready bus (master side)
//   o_inst_out     : IF/ID instruction
//   o_pc_out       : IF/ID PC+4 of o_inst_out
//   o_valid_id     : IF/ID holds a real instruction
//   o_flush_id     : one-cycle pulse after the IF/ID slot was squashed
module fetch_if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_hold_pc,
    input  logic                     i_hold_if,
    input  logic                     i_br,
    input  logic [31:0]              i_pc_branch,
    input  logic                     i_exception,
    fetch_if_stage_if.master         imem,
    output logic [31:0]              o_inst_out,
    output logic [31:0]              o_pc_out,
    output logic                     o_valid_id,
    output logic                     o_flush_id
);
    typedef enum logic [1:0] {IDLE, FETCH, BUFFERED, DRAIN} state_t;
    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc, r_inst, w_inst, r_pc_out, w_pc_out;
    logic [31:0] r_buf_inst, w_buf_inst, r_buf_pc, w_buf_pc, r_drain_addr, w_drain_addr;
    logic        r_valid, w_valid, r_flush, w_flush;
    logic        w_redir;
    logic [31:0] w_target, w_pc_inc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= NOP;
            r_pc_out     <= 32'd0;
            r_valid      <= 1'b0;
            r_flush      <= 1'b0;
            r_buf_inst   <= 32'd0;
            r_buf_pc     <= 32'd0;
            r_drain_addr <= 32'd0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_inst       <= w_inst;
            r_pc_out     <= w_pc_out;
            r_valid      <= w_valid;
            r_flush      <= w_flush;
            r_buf_inst   <= w_buf_inst;
            r_buf_pc     <= w_buf_pc;
            r_drain_addr <= w_drain_addr;
        end
    end
    always_comb begin
        w_redir      = i_exception | (i_br & ~i_hold_if);
        w_target     = i_exception ? EXC_VECTOR : (i_pc_branch & ~32'd3);
        w_pc_inc     = r_pc + 32'd4;
        w_state      = r_state;
        w_pc         = r_pc;
        w_inst       = r_inst;
        w_pc_out     = r_pc_out;
        w_valid      = r_valid;
        w_flush      = 1'b0;
        w_buf_inst   = r_buf_inst;
        w_buf_pc     = r_buf_pc;
        w_drain_addr = r_drain_addr;
        imem.req     = 1'b0;
        imem.addr    = r_pc;
        case (r_state)
            IDLE: w_state = FETCH;
            FETCH: begin
                imem.req = ~i_hold_pc;
                if (w_redir) begin
                    // an issued request that is not answered yet must be drained and its data dropped
                    w_state      = (~i_hold_pc & ~imem.ready) ? DRAIN : FETCH;
                    w_drain_addr = r_pc;
                    w_pc         = w_target;
                    w_inst       = NOP;
                    w_valid      = 1'b0;
                    w_flush      = 1'b1;
                end else if (imem.ready & i_hold_if) begin
                    w_state    = BUFFERED;
                    w_buf_inst = imem.rdata;
                    w_buf_pc   = w_pc_inc;
                    w_pc       = w_pc_inc;
                end else if (imem.ready) begin
                    w_inst   = imem.rdata;
                    w_pc_out = w_pc_inc;
                    w_valid  = 1'b1;
                    w_pc     = w_pc_inc;
                end else if (~i_hold_if) begin
                    w_inst  = NOP;
                    w_valid = 1'b0;
                end
            end
            BUFFERED: begin
                if (w_redir) begin
                    w_state = FETCH;
                    w_pc    = w_target;
                    w_inst  = NOP;
                    w_valid = 1'b0;
                    w_flush = 1'b1;
                end else if (~i_hold_if) begin
                    w_state  = FETCH;
                    w_inst   = r_buf_inst;
                    w_pc_out = r_buf_pc;
                    w_valid  = 1'b1;
                end
            end
            DRAIN: begin
                // the old request stays up at its own address; a further redirect only retargets
                imem.req  = 1'b1;
                imem.addr = r_drain_addr;
                w_pc      = w_redir ? w_target : r_pc;
                w_state   = imem.ready ? FETCH : DRAIN;
            end
            default: w_state = IDLE;
        endcase
    end
    assign o_inst_out = r_inst;
    assign o_pc_out   = r_pc_out;
    assign o_valid_id = r_valid;
    assign o_flush_id = r_flush;
endmodule
